// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock keypad front end: key codes,
// scan state encoding, row drive pattern and the row/column key map.
// ACLK_KEYPAD_SYMBOL_EN: when defined, * and # map to KEY_STAR / KEY_HASH.
package aclk_pkg;

  localparam int COLS = 3;
  localparam int ROWS = 4;

  localparam logic [3:0] NOKEY    = 4'd10;
  localparam logic [3:0] KEY_STAR = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd12;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } scan_state_t;

  // Active-low one-hot drive for a row index.
  function automatic logic [ROWS-1:0] row_drive(input logic [1:0] row);
    logic [ROWS-1:0] drv;
    case (row)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      2'd3:    drv = 4'b0111;
      default: drv = 4'b1111;
    endcase
    return drv;
  endfunction

  // Column index of a single low bit; 3 when zero or several bits are low.
  function automatic logic [1:0] col_index(input logic [COLS-1:0] cs);
    logic [1:0] idx;
    case (cs)
      3'b110:  idx = 2'd0;
      3'b101:  idx = 2'd1;
      3'b011:  idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Key code at a row/column position; NOKEY for positions never accepted.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b11_01: code = 4'd0;
`ifdef ACLK_KEYPAD_SYMBOL_EN
      4'b11_00: code = KEY_STAR;
      4'b11_10: code = KEY_HASH;
`endif
      default:  code = NOKEY;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/aclk_col_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad columns.
// Resets to all-ones (no key) so the scanner sees an idle keypad after reset.
module aclk_col_sync
  import aclk_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] d,
  output logic [COLS-1:0] q
);

  logic [COLS-1:0] meta;

  // Two-stage capture of the raw column lines.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 3'b111;
      q    <= 3'b111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aclk_keypad_scan.sv
// Keypad scanner for the alarm clock: drives rows, samples synchronized
// columns, debounces a single key and reports it as a 4-bit code with a
// one-cycle strobe on each accepted press.
// ACLK_KEYPAD_SYMBOL_EN: when defined, * (11) and # (12) are accepted too.
module aclk_keypad_scan
  import aclk_pkg::*;
#(
  parameter int SCAN_DIV   = 256,
  parameter int DEB_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  row_n,
  input  logic [2:0]  col_n,
  output logic [3:0]  key,
  output logic        key_strobe
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEB_CYCLES);

  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SW_ONE    = SW'(1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DW_ONE    = DW'(1);

  scan_state_t     state;
  logic [1:0]      row;
  logic [SW-1:0]   div_cnt;
  logic [DW-1:0]   deb_cnt;
  logic [DW-1:0]   deb_next;
  logic [2:0]      cs;
  logic [2:0]      pat;
  logic [3:0]      code_lat;
  logic [3:0]      scan_code;
  logic            scan_hit;

  aclk_col_sync u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col_n),
    .q     (cs)
  );

  // Decode the synchronized columns of the driven row into a candidate key.
  always_comb begin
    scan_code = key_map(row, col_index(cs));
    scan_hit  = (scan_code != NOKEY);
  end

  // Debounce count of the next matching sample, held at its ceiling.
  always_comb begin
    if (deb_cnt == DEB_LAST) begin
      deb_next = deb_cnt;
    end else begin
      deb_next = deb_cnt + DW_ONE;
    end
  end

  // Scan/debounce state machine with registered row drive, key and strobe.
  // The sample that enters a debounce state counts as the first stable one,
  // so acceptance happens on the DEB_CYCLES-th consecutive stable sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= SCAN;
      row        <= 2'd0;
      row_n      <= 4'b1110;
      div_cnt    <= '0;
      deb_cnt    <= '0;
      pat        <= 3'b111;
      code_lat   <= NOKEY;
      key        <= NOKEY;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      case (state)
        SCAN: begin
          if (div_cnt == SLOT_LAST) begin
            div_cnt <= '0;
            if (scan_hit) begin
              pat      <= cs;
              code_lat <= scan_code;
              deb_cnt  <= '0;
              state    <= DEB_PRESS;
            end else begin
              row   <= row + 2'd1;
              row_n <= row_drive(row + 2'd1);
            end
          end else begin
            div_cnt <= div_cnt + SW_ONE;
          end
        end
        DEB_PRESS: begin
          if (cs == pat) begin
            deb_cnt <= deb_next;
            if (deb_next == DEB_LAST) begin
              key        <= code_lat;
              key_strobe <= 1'b1;
              state      <= HELD;
            end
          end else begin
            // Bounce: give up on this key and resume at the following row.
            state   <= SCAN;
            div_cnt <= '0;
            row     <= row + 2'd1;
            row_n   <= row_drive(row + 2'd1);
          end
        end
        HELD: begin
          if (cs == 3'b111) begin
            deb_cnt <= '0;
            state   <= DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (cs == 3'b111) begin
            deb_cnt <= deb_next;
            if (deb_next == DEB_LAST) begin
              key     <= NOKEY;
              state   <= SCAN;
              div_cnt <= '0;
              row     <= row + 2'd1;
              row_n   <= row_drive(row + 2'd1);
            end
          end else begin
            // Short release: the key is still considered held, no new strobe.
            state <= HELD;
          end
        end
        default: begin
          state   <= SCAN;
          div_cnt <= '0;
          row     <= 2'd0;
          row_n   <= 4'b1110;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aclk_keypad_scan.sv
// Self-checking bench for aclk_keypad_scan with a physical keypad model
// (pressed switches connect driven rows to columns) and a reference key map.
module tb_aclk_keypad_scan;

  localparam int SCAN_DIV    = 4;
  localparam int DEB_CYCLES  = 8;
  localparam int PRESS_BOUND = 2 + 4 * SCAN_DIV + DEB_CYCLES;
  localparam int REL_LAT     = 2 + DEB_CYCLES;
  localparam int NOKEY_I     = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [3:0] key;
  logic       key_strobe;

  logic [11:0] pressed = '0;
  logic        glitch = 1'b0;
  logic        force_en = 1'b1;
  logic [2:0]  force_val = 3'b111;
  logic [2:0]  model_col;

  int tests_run = 0;
  int tests_failed = 0;
  int strobe_cnt = 0;
  int consec = 0;
  logic prev_strobe = 1'b0;

  aclk_keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .row_n      (row_n),
    .col_n      (col_n),
    .key        (key),
    .key_strobe (key_strobe)
  );

  always #5 clk = ~clk;

  // Keypad switch matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    model_col = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r*3+c] && (row_n[r] === 1'b0)) model_col[c] = 1'b0;
      end
    end
    if (glitch) model_col = 3'b111;
    col_n = force_en ? force_val : model_col;
  end

  // Strobe monitor: count strobes and flag back-to-back strobes.
  always @(negedge clk) begin
    if (key_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    if (key_strobe === 1'b1 && prev_strobe === 1'b1) consec <= consec + 1;
    prev_strobe <= key_strobe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_code(input int r, input int c);
    if (r < 3) return r * 3 + c + 1;
    if (c == 1) return 0;
`ifdef ACLK_KEYPAD_SYMBOL_EN
    return (c == 0) ? 11 : 12;
`else
    return NOKEY_I;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int bound, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < bound && !seen) begin
      tick();
      n++;
      if (key_strobe === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_key(input logic [3:0] val, input int bound, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < bound && !seen) begin
      tick();
      n++;
      if (key === val) seen = 1'b1;
    end
  endtask

  task automatic wait_row(input logic [3:0] val, output bit seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (n < 64 && !seen) begin
      tick();
      n++;
      if (row_n === val) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    force_en = 1'b1;
    force_val = 3'b011;
    repeat (3) begin
      tick();
      tests_run++;
      if (row_n !== 4'b1110 || key !== 4'd10 || key_strobe !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold: row_n=%b key=%0d strobe=%b, required 1110/10/0", row_n, key, key_strobe);
      end
    end
    reset = 1'b1;
    force_en = 1'b0;
    tick();
    tests_run++;
    if (row_n !== 4'b1110 || key !== 4'd10 || key_strobe !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_exit: row_n=%b key=%0d strobe=%b, required 1110/10/0", row_n, key, key_strobe);
    end
  endtask

  task automatic test_digit5();
    int n;
    bit seen;
    int s0;
    int bad;
    s0 = strobe_cnt;
    pressed = '0;
    pressed[4] = 1'b1;
    wait_strobe(PRESS_BOUND, n, seen);
    tests_run++;
    if (!seen || key !== 4'd5) begin
      tests_failed++;
      $display("FAIL digit5_press: strobe_seen=%0d key=%0d after %0d cycles, required strobe and key 5 within %0d", seen, key, n, PRESS_BOUND);
    end
    bad = 0;
    repeat (12) begin
      tick();
      if (key !== 4'd5 || key_strobe !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || strobe_cnt - s0 != 1) begin
      tests_failed++;
      $display("FAIL digit5_hold: %0d bad cycles, %0d strobes, required 0 bad and 1 strobe", bad, strobe_cnt - s0);
    end
    pressed = '0;
    wait_key(4'd10, 3 * REL_LAT, n, seen);
    tests_run++;
    if (!seen || n != REL_LAT) begin
      tests_failed++;
      $display("FAIL digit5_release: key=10 after %0d cycles (seen=%0d), required exactly %0d", n, seen, REL_LAT);
    end
  endtask

  task automatic test_bounce();
    int n;
    bit seen;
    int s0;
    s0 = strobe_cnt;
    wait_row(4'b1110, seen);
    pressed = '0;
    pressed[6] = 1'b1;
    wait_row(4'b1011, seen);
    repeat (SCAN_DIV + 2) tick();
    tests_run++;
    if (row_n !== 4'b1011 || strobe_cnt != s0) begin
      tests_failed++;
      $display("FAIL bounce_debouncing: row_n=%b strobes=%0d, required row 1011 frozen and 0 strobes", row_n, strobe_cnt - s0);
    end
    glitch = 1'b1;
    tick();
    glitch = 1'b0;
    wait_strobe(80, n, seen);
    tests_run++;
    if (!seen || n < DEB_CYCLES || key !== 4'd7) begin
      tests_failed++;
      $display("FAIL bounce_accept: strobe_seen=%0d after %0d cycles key=%0d, required strobe no sooner than %0d and key 7", seen, n, key, DEB_CYCLES);
    end
    tick();
    tests_run++;
    if (strobe_cnt - s0 != 1) begin
      tests_failed++;
      $display("FAIL bounce_strobes: %0d strobes, required 1", strobe_cnt - s0);
    end
    pressed = '0;
    wait_key(4'd10, 3 * REL_LAT, n, seen);
  endtask

  task automatic test_two_keys();
    int n;
    bit seen;
    int s0;
    int bad;
    s0 = strobe_cnt;
    pressed = '0;
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    bad = 0;
    repeat (10 * SCAN_DIV) begin
      tick();
      if (key !== 4'd10 || key_strobe !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL two_keys_ignored: %0d cycles with key/strobe active, required 0", bad);
    end
    pressed[1] = 1'b0;
    wait_strobe(PRESS_BOUND, n, seen);
    tests_run++;
    if (!seen || key !== 4'd1) begin
      tests_failed++;
      $display("FAIL two_keys_single: strobe_seen=%0d key=%0d, required strobe and key 1", seen, key);
    end
    pressed = '0;
    wait_key(4'd10, 3 * REL_LAT, n, seen);
  endtask

  task automatic test_release_bounce();
    int n;
    bit seen;
    int s0;
    int bad;
    pressed = '0;
    pressed[8] = 1'b1;
    wait_strobe(PRESS_BOUND, n, seen);
    tests_run++;
    if (!seen || key !== 4'd9) begin
      tests_failed++;
      $display("FAIL relbounce_press: strobe_seen=%0d key=%0d, required strobe and key 9", seen, key);
    end
    tick();
    s0 = strobe_cnt;
    pressed = '0;
    repeat (3) tick();
    pressed[8] = 1'b1;
    bad = 0;
    repeat (30) begin
      tick();
      if (key !== 4'd9) bad++;
    end
    tests_run++;
    if (bad != 0 || strobe_cnt != s0) begin
      tests_failed++;
      $display("FAIL relbounce_hold: %0d cycles key!=9, %0d new strobes, required 0 and 0", bad, strobe_cnt - s0);
    end
    pressed = '0;
    wait_key(4'd10, 3 * REL_LAT, n, seen);
    tests_run++;
    if (!seen || n != REL_LAT) begin
      tests_failed++;
      $display("FAIL relbounce_release: key=10 after %0d cycles (seen=%0d), required exactly %0d", n, seen, REL_LAT);
    end
  endtask

  task automatic test_symbol();
    int n;
    bit seen;
    int exp;
    exp = exp_code(3, 2);
    pressed = '0;
    pressed[11] = 1'b1;
    wait_strobe(2 * PRESS_BOUND, n, seen);
    tests_run++;
    if (seen != (exp != NOKEY_I) || key !== 4'(exp)) begin
      tests_failed++;
      $display("FAIL symbol_hash: strobe_seen=%0d key=%0d, required strobe=%0d key=%0d", seen, key, exp != NOKEY_I, exp);
    end
    pressed = '0;
    wait_key(4'd10, 3 * REL_LAT, n, seen);
  endtask

  task automatic test_mid_reset();
    bit seen;
    int s0;
    s0 = strobe_cnt;
    wait_row(4'b1110, seen);
    pressed = '0;
    pressed[3] = 1'b1;
    wait_row(4'b1101, seen);
    repeat (SCAN_DIV + 2) tick();
    tests_run++;
    if (row_n !== 4'b1101 || strobe_cnt != s0) begin
      tests_failed++;
      $display("FAIL midreset_debouncing: row_n=%b strobes=%0d, required 1101 and 0", row_n, strobe_cnt - s0);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (row_n !== 4'b1110 || key !== 4'd10 || key_strobe !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_values: row_n=%b key=%0d strobe=%b, required 1110/10/0", row_n, key, key_strobe);
    end
    pressed = '0;
    tick();
    reset = 1'b1;
    repeat (2 * PRESS_BOUND) tick();
    tests_run++;
    if (strobe_cnt != s0 || key !== 4'd10) begin
      tests_failed++;
      $display("FAIL midreset_nostrobe: %0d strobes key=%0d, required 0 and 10", strobe_cnt - s0, key);
    end
  endtask

  task automatic test_random();
    int n;
    bit seen;
    int s0;
    int r;
    int c;
    int exp;
    int hold;
    for (int it = 0; it < 16; it++) begin
      r = int'($urandom_range(3, 0));
      c = int'($urandom_range(2, 0));
      exp = exp_code(r, c);
      s0 = strobe_cnt;
      pressed = '0;
      pressed[r*3+c] = 1'b1;
      wait_strobe(PRESS_BOUND, n, seen);
      tests_run++;
      if (seen != (exp != NOKEY_I) || key !== 4'(exp)) begin
        tests_failed++;
        $display("FAIL random_press[%0d] r%0d c%0d: strobe_seen=%0d key=%0d after %0d, required strobe=%0d key=%0d", it, r, c, seen, key, n, exp != NOKEY_I, exp);
      end
      hold = int'($urandom_range(15, 0));
      repeat (hold) tick();
      tests_run++;
      if (key !== 4'(exp)) begin
        tests_failed++;
        $display("FAIL random_hold[%0d]: key=%0d, required %0d", it, key, exp);
      end
      pressed = '0;
      if (exp != NOKEY_I) begin
        wait_key(4'd10, 3 * REL_LAT, n, seen);
        tests_run++;
        if (!seen || n != REL_LAT) begin
          tests_failed++;
          $display("FAIL random_release[%0d]: key=10 after %0d (seen=%0d), required exactly %0d", it, n, seen, REL_LAT);
        end
      end
      tick();
      tests_run++;
      if (strobe_cnt - s0 != ((exp != NOKEY_I) ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL random_strobes[%0d]: %0d strobes, required %0d", it, strobe_cnt - s0, (exp != NOKEY_I) ? 1 : 0);
      end
      repeat (int'($urandom_range(10, 0))) tick();
    end
  endtask

  initial begin
    test_reset();
    test_digit5();
    test_bounce();
    test_two_keys();
    test_release_bounce();
    test_symbol();
    test_mid_reset();
    test_random();
    tick();
    tests_run++;
    if (consec != 0) begin
      tests_failed++;
      $display("FAIL strobe_consecutive: %0d back-to-back strobes, required 0", consec);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/aclk_keypad_scan.md
# aclk_keypad_scan

Matrix-keypad front end for the alarm clock. It drives the row lines of a 4x3 telephone keypad and samples the column lines. It debounces one key at a time and presents the result as the 4-bit `key` code that the alarm-clock controller and key register consume. `key` holds the digit while a key is held down and holds `NOKEY` (4'd10) otherwise. A one-cycle strobe marks each new debounced press.

## Interface
- `SCAN_DIV`, 256: clock cycles each row stays driven while scanning; minimum 4.
- `DEB_CYCLES`, 1000: consecutive stable synchronized samples required to accept a press or a release; minimum 2.
- `clk` in 1: system clock, the same clock as the rest of the alarm clock.
- `reset` in 1: synchronous, active-low reset. It is sampled on the rising edge of `clk`, and `reset==0` resets the block.
- `row_n` out 4: row drive, active-low one-hot. Bit 0 is row 0 (keys 1, 2, 3) and bit 3 is row 3 (keys *, 0, #).
- `col_n` in 3: raw column inputs, active-low, pulled up externally, asynchronous to `clk`. Bit 0 is the left column.
- `key` out 4: debounced key code, 0–9, or `NOKEY`=10 when no key is accepted.
- `key_strobe` out 1: high for exactly one cycle, in the cycle `key` takes a newly accepted press code.

## Operation
- `col_n` passes through a 2-flop synchronizer. All decisions use the synchronized value `cs`.
- The key map is:
  - row 0: 1, 2, 3
  - row 1: 4, 5, 6
  - row 2: 7, 8, 9
  - row 3: *, 0, #
- **SCAN** state:
  - A row counter advances 0→1→2→3→0 every `SCAN_DIV` cycles, and `row_n` follows it.
  - `cs` is examined only in the last cycle of each row slot, so that the synchronizer has settled.
  - Exactly one bit of `cs` low: latch the row and column, clear the debounce counter, go to **DEB_PRESS**.
  - Zero bits, or two or more bits low: stay in SCAN. Multiple keys in one row are ignored.
- **DEB_PRESS** state:
  - The row is frozen.
  - Each cycle that `cs` equals the latched pattern, the counter increments.
  - Any mismatch returns the block to SCAN at the next row.
  - When the counter reaches `DEB_CYCLES`-1 with a match:
    - `key` takes the mapped code and `key_strobe` pulses.
    - The state goes to **HELD**.
- **HELD** state:
  - The row stays frozen and `key` is held.
  - When `cs` becomes all-ones, the counter is cleared and the state goes to **DEB_RELEASE**.
  - Extra keys pressed in the same row are ignored, and `key` is unchanged.
- **DEB_RELEASE** state:
  - Each cycle that `cs` is all-ones, the counter increments. Any low bit returns the block to HELD without a new strobe.
  - When the counter reaches `DEB_CYCLES`-1:
    - `key` becomes `NOKEY`.
    - The state goes to SCAN, starting from the row after the latched one.
- Unmapped positions (* and #) are not accepted unless the macro in Configuration is defined. Without it, SCAN treats them as zero bits low.
- Counter widths are `$clog2(SCAN_DIV)` and `$clog2(DEB_CYCLES)` bits. Counters saturate and never wrap.

## Timing
- **Reset values:** `row_n`=4'b1110, `key`=4'd10, `key_strobe`=0, state SCAN, all counters 0, synchronizer flops all-ones.
- Reset is synchronous at any point, including mid-debounce or in HELD. On the next edge all outputs take their reset values and no strobe is produced.
- **Press latency:** from a `col_n` edge that is stable and in the driven row to `key` valid is 2 cycles (synchronizer) + wait until the end of the row slot + `DEB_CYCLES` cycles. Worst case is 2 + 4·`SCAN_DIV` + `DEB_CYCLES`.
- **Release latency:** from `col_n` returning all-high to `key`=`NOKEY` is 2 + `DEB_CYCLES` cycles.
- `key_strobe` and the `key` update occur in the same cycle. `key_strobe` never occurs in two consecutive cycles.
- Between presses, `key` is `NOKEY` for at least one full release debounce.

## Configuration
- `ACLK_KEYPAD_SYMBOL_EN` defined:
  - * is accepted as 4'd11 and # as 4'd12, with the same debounce and strobe as digits.
- Not defined:
  - * and # are never accepted; the `key` range is 0–10 only.
  - No logic for codes 11/12 is generated.

## Structure
- Shared package `aclk_pkg`:
  - `NOKEY`=4'd10, `KEY_STAR`=4'd11, `KEY_HASH`=4'd12;
  - the scan state enum (SCAN, DEB_PRESS, HELD, DEB_RELEASE);
  - the row/column-to-code mapping function.
- Sub-module `aclk_col_sync`: a 3-bit 2-flop synchronizer with reset value all-ones. The FSM, counters and row drive stay in the top module.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEB_CYCLES`=8.
- **Reset:** hold `reset`=0 for 3 cycles with `col_n`=3'b011 → `row_n`=4'b1110, `key`=10, `key_strobe`=0 throughout.
- **Digit 5:** assert col 1 low whenever row 1 is driven, and hold it → `key`=5 with one strobe within 2+16+8 cycles. Release → `key`=10 exactly 10 cycles later.
- **Bounce:** col 0 low in row 2, toggled high for 1 cycle at debounce count 5, then held low → no strobe until 8 fresh stable cycles after the glitch. `key`=7, one strobe total.
- **Two keys in one row:** `col_n`=3'b100 in row 0 → `key` stays 10 and no strobe. Release one key so only col 0 remains low → `key`=1.
- **Release bounce in HELD:** `key`=9 held; a 3-cycle release is followed by a re-press → `key` stays 9 with no second strobe. A full release then gives `key`=10.
- **Symbol key and mid-debounce reset:** row 3, col 2 (#):
  - with `ACLK_KEYPAD_SYMBOL_EN` → `key`=12;
  - without it → `key`=10 and no strobe.
  - Separately, `reset`=0 asserted mid-DEB_PRESS on digit 4 → no strobe, and outputs return to their reset values on the next edge.
